// File: rtl/mem_port_router_pkg.sv
// Shared definitions for the external memory port router: router states,
// layer/engine encodings and a width helper.
package mem_port_router_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } rtr_state_e;

   localparam logic [4:0] LAYER_FC   = 5'd0;
   localparam logic [4:0] LAYER_CONV = 5'd1;
   localparam logic [4:0] LAYER_POOL = 5'd2;
   localparam logic [4:0] LAYER_ACT  = 5'd3;

   localparam int ENG_FC   = 0;
   localparam int ENG_CONV = 1;
   localparam int ENG_POOL = 2;
   localparam int ENG_ACT  = 3;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_port_router_outst_counter.sv
// Outstanding read counter: +1 per issued read, -1 per returned response,
// with full/empty flags for grant throttling and spurious-response detection.
module mem_port_router_outst_counter
   import mem_port_router_pkg::*;
#(
   parameter int MAX_OUTST = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   input  logic dec_i,
   output logic full_o,
   output logic empty_o
);

   localparam int CNT_W = clog2_min1(MAX_OUTST + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      case ({inc_i, dec_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign full_o  = (count_q == CNT_W'(MAX_OUTST));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/mem_port_router.sv
// Routes one of NUM_ENG engines onto the single external memory port and
// drains in-flight reads before switching so responses reach the issuing engine.
module mem_port_router
   import mem_port_router_pkg::*;
#(
   parameter int  NUM_ENG   = 4,
   parameter int  SEL_W     = 5,
   parameter int  ADDR_W    = 26,
   parameter int  DATA_W    = 32,
   parameter int  MAX_OUTST = 8,
   localparam int IDX_W     = clog2_min1(NUM_ENG)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [SEL_W-1:0]          sel,
   input  logic [NUM_ENG-1:0]        eng_wvalid,
   output logic [NUM_ENG-1:0]        eng_wready,
   input  logic [NUM_ENG*ADDR_W-1:0] eng_waddr,
   input  logic [NUM_ENG*DATA_W-1:0] eng_wdata,
   input  logic [NUM_ENG-1:0]        eng_rvalid,
   output logic [NUM_ENG-1:0]        eng_rgrant,
   input  logic [NUM_ENG*ADDR_W-1:0] eng_raddr,
   output logic [NUM_ENG-1:0]        eng_rready,
   output logic [NUM_ENG*DATA_W-1:0] eng_rdata,
   output logic                      mem_wvalid,
   output logic [ADDR_W-1:0]         mem_waddr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic                      mem_wready,
   output logic                      mem_rvalid,
   output logic [ADDR_W-1:0]         mem_raddr,
   input  logic                      mem_rready,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic [IDX_W-1:0]          active_idx,
   output logic                      busy,
   output logic                      err_spurious
);

   rtr_state_e       state_q;
   logic [IDX_W-1:0] active_idx_q;
   logic             err_q;

   logic             full_s;
   logic             empty_s;
   logic             grant_s;
   logic             rsp_fwd_s;
   logic             spurious_s;
   logic             sel_ok_s;
   logic             sel_match_s;
   logic [IDX_W-1:0] sel_idx_s;

   assign sel_ok_s    = (32'(sel) < NUM_ENG);
   assign sel_match_s = (32'(sel) == 32'(active_idx_q));
   assign sel_idx_s   = sel[IDX_W-1:0];

   // A response with nothing outstanding is never forwarded to an engine.
   assign rsp_fwd_s  = mem_rready & ~empty_s;
   assign spurious_s = mem_rready & empty_s;

   mem_port_router_outst_counter #(
      .MAX_OUTST (MAX_OUTST)
   ) u_outst (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (grant_s),
      .dec_i   (rsp_fwd_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         active_idx_q <= '0;
         err_q        <= 1'b0;
      end else begin
         err_q <= err_q | spurious_s;
         case (state_q)
            ST_IDLE: begin
               if (sel_ok_s) begin
                  active_idx_q <= sel_idx_s;
                  state_q      <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (!sel_match_s) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Leave only once the old engine has no reads or writes pending.
               if (empty_s && !eng_wvalid[active_idx_q]) begin
                  if (sel_ok_s) begin
                     active_idx_q <= sel_idx_s;
                     state_q      <= ST_ACTIVE;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      grant_s    = 1'b0;
      mem_wvalid = 1'b0;
      mem_waddr  = '0;
      mem_wdata  = '0;
      mem_rvalid = 1'b0;
      mem_raddr  = '0;
      eng_wready = '0;
      eng_rgrant = '0;
      eng_rready = '0;
      eng_rdata  = '0;
      if (state_q != ST_IDLE) begin
         mem_wvalid                                   = eng_wvalid[active_idx_q];
         mem_waddr                                    = eng_waddr[int'(active_idx_q)*ADDR_W +: ADDR_W];
         mem_wdata                                    = eng_wdata[int'(active_idx_q)*DATA_W +: DATA_W];
         eng_wready[active_idx_q]                     = mem_wready;
         eng_rready[active_idx_q]                     = rsp_fwd_s;
         eng_rdata[int'(active_idx_q)*DATA_W +: DATA_W] = mem_rdata;
      end else begin
         mem_wvalid = 1'b0;
      end
      if (state_q == ST_ACTIVE) begin
         grant_s   = eng_rvalid[active_idx_q] & ~full_s;
         mem_raddr = eng_raddr[int'(active_idx_q)*ADDR_W +: ADDR_W];
      end else begin
         grant_s = 1'b0;
      end
      mem_rvalid               = grant_s;
      eng_rgrant[active_idx_q] = grant_s;
   end

   assign active_idx   = active_idx_q;
   assign busy         = (state_q != ST_ACTIVE);
   assign err_spurious = err_q;

endmodule
